// File: rtl/pulse_cnt_sched.sv
// rtl/pulse_cnt_sched.sv - measurement-window scheduler: clear, gate, settle, snapshot, stream out
// Optional: PULSE_CNT_SCHED_SKIP_ZERO_EN skips zero-valued snapshots during readout.
module pulse_cnt_sched #(
  parameter int SETTLE_CYCLES = 4,
  parameter int GATE_W        = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_cont,
  input  logic [GATE_W-1:0] i_gate_len,
  input  logic [15:0]       i_cnt0,
  input  logic [15:0]       i_cnt1,
  input  logic [15:0]       i_cnt2,
  input  logic [15:0]       i_cnt3,
  output logic              o_cnt_clr,
  output logic              o_cnt_en,
  output logic              o_rd_valid,
  output logic [1:0]        o_rd_ch,
  output logic [15:0]       o_rd_cnt,
  input  logic              i_rd_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_trunc,
  output logic [15:0]       o_win_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, CAPTURE, OUT} state_t;

  localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES);
  localparam logic [GATE_W-1:0] ONE         = GATE_W'(1);

  state_t            state, state_nxt;
  logic [GATE_W-1:0] gate_len, gate_len_nxt;
  logic [GATE_W-1:0] tmr, tmr_nxt;
  logic              cont, cont_nxt;
  logic              stop_pend, stop_pend_nxt;
  logic              trunc, trunc_nxt;
  logic [3:0][15:0]  snap, snap_nxt, in_cnt;
  logic [3:0]        nz_in, nz_snap;
  logic              valid_nxt, done_nxt, finish;
  logic [1:0]        ch_nxt;
  logic [15:0]       rd_cnt_nxt, win_nxt;
  logic [2:0]        sel;

  assign in_cnt = {i_cnt3, i_cnt2, i_cnt1, i_cnt0};

`ifdef PULSE_CNT_SCHED_SKIP_ZERO_EN
  assign nz_in   = {|i_cnt3, |i_cnt2, |i_cnt1, |i_cnt0};
  assign nz_snap = {|snap[3], |snap[2], |snap[1], |snap[0]};
`else
  assign nz_in   = 4'hF;
  assign nz_snap = 4'hF;
`endif

  // Lowest eligible channel at or above 'from'; 4 means nothing left to present.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= from && mask[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_nxt     = state;
    gate_len_nxt  = gate_len;
    tmr_nxt       = tmr;
    cont_nxt      = cont;
    stop_pend_nxt = stop_pend;
    trunc_nxt     = trunc;
    snap_nxt      = snap;
    valid_nxt     = o_rd_valid;
    ch_nxt        = o_rd_ch;
    rd_cnt_nxt    = o_rd_cnt;
    done_nxt      = 1'b0;
    win_nxt       = o_win_cnt;
    finish        = 1'b0;
    sel           = 3'd4;

    if (state != IDLE && i_stop) stop_pend_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (i_start && !i_stop) begin
          gate_len_nxt = (i_gate_len == '0) ? ONE : i_gate_len;
          cont_nxt     = i_cont;
          trunc_nxt    = 1'b0;
          state_nxt    = CLEAR;
        end
      end
      CLEAR: begin
        tmr_nxt   = gate_len;
        trunc_nxt = 1'b0;
        state_nxt = GATE;
      end
      GATE: begin
        if (i_stop) begin
          trunc_nxt = 1'b1;
          tmr_nxt   = SETTLE_LOAD;
          state_nxt = SETTLE;
        end else if (tmr == ONE) begin
          tmr_nxt   = SETTLE_LOAD;
          state_nxt = SETTLE;
        end else begin
          tmr_nxt = tmr - ONE;
        end
      end
      SETTLE: begin
        if (tmr == ONE) state_nxt = CAPTURE;
        else            tmr_nxt   = tmr - ONE;
      end
      CAPTURE: begin
        snap_nxt = in_cnt;
        sel      = pick(nz_in, 3'd0);
        if (sel[2]) begin
          finish = 1'b1;
        end else begin
          state_nxt  = OUT;
          valid_nxt  = 1'b1;
          ch_nxt     = sel[1:0];
          rd_cnt_nxt = in_cnt[sel[1:0]];
        end
      end
      OUT: begin
        if (o_rd_valid && i_rd_ready) begin
          sel = pick(nz_snap, {1'b0, o_rd_ch} + 3'd1);
          if (sel[2]) begin
            finish = 1'b1;
          end else begin
            ch_nxt     = sel[1:0];
            rd_cnt_nxt = snap[sel[1:0]];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Window complete: a stop seen this cycle also ends continuous mode.
    if (finish) begin
      done_nxt   = 1'b1;
      win_nxt    = o_win_cnt + 16'd1;
      valid_nxt  = 1'b0;
      ch_nxt     = 2'd0;
      rd_cnt_nxt = 16'd0;
      if (cont && !stop_pend && !i_stop) begin
        state_nxt = CLEAR;
      end else begin
        state_nxt     = IDLE;
        stop_pend_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      gate_len   <= '0;
      tmr        <= '0;
      cont       <= 1'b0;
      stop_pend  <= 1'b0;
      trunc      <= 1'b0;
      snap       <= '0;
      o_cnt_clr  <= 1'b0;
      o_cnt_en   <= 1'b0;
      o_busy     <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_ch    <= 2'd0;
      o_rd_cnt   <= 16'd0;
      o_done     <= 1'b0;
      o_trunc    <= 1'b0;
      o_win_cnt  <= 16'd0;
    end else begin
      state      <= state_nxt;
      gate_len   <= gate_len_nxt;
      tmr        <= tmr_nxt;
      cont       <= cont_nxt;
      stop_pend  <= stop_pend_nxt;
      trunc      <= trunc_nxt;
      snap       <= snap_nxt;
      o_cnt_clr  <= (state_nxt == CLEAR);
      o_cnt_en   <= (state_nxt == GATE);
      o_busy     <= (state_nxt != IDLE);
      o_rd_valid <= valid_nxt;
      o_rd_ch    <= ch_nxt;
      o_rd_cnt   <= rd_cnt_nxt;
      o_done     <= done_nxt;
      o_trunc    <= valid_nxt & trunc_nxt;
      o_win_cnt  <= win_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_cnt_sched.sv
// tb/tb_pulse_cnt_sched.sv - randomized self-checking bench for pulse_cnt_sched
// Counter bank and pulse source are modelled here; expected words come from pulses injected while gated.
`timescale 1ns/1ps
module tb_pulse_cnt_sched;
  localparam int S  = 4;
  localparam int GW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, cont = 1'b0, rd_ready = 1'b1;
  logic [GW-1:0] gate_len = '0;
  logic [15:0]   bank [4];
  logic          cnt_clr, cnt_en, rd_valid, busy, done, trunc;
  logic [1:0]    rd_ch;
  logic [15:0]   rd_cnt, win_cnt;

  int checks = 0, errors = 0, exp_win = 0;
  int exp_ch[$], exp_cnt[$];

  always #5 clk = ~clk;

  pulse_cnt_sched #(.SETTLE_CYCLES(S), .GATE_W(GW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_cont(cont),
    .i_gate_len(gate_len), .i_cnt0(bank[0]), .i_cnt1(bank[1]), .i_cnt2(bank[2]), .i_cnt3(bank[3]),
    .o_cnt_clr(cnt_clr), .o_cnt_en(cnt_en), .o_rd_valid(rd_valid), .o_rd_ch(rd_ch),
    .o_rd_cnt(rd_cnt), .i_rd_ready(rd_ready), .o_busy(busy), .o_done(done),
    .o_trunc(trunc), .o_win_cnt(win_cnt));

  // Pulse source: 0 idle, 1 ch1-3 for the first 10 gated cycles, 2 random.
  int         pulse_mode = 0;
  logic [3:0] pulse = 4'd0;
  int         gate_age = 0;
  always @(posedge clk) begin
    #1;
    gate_age = cnt_en ? gate_age + 1 : 0;
    case (pulse_mode)
      1:       pulse = (cnt_en && gate_age <= 10) ? 4'b1110 : 4'b0000;
      2:       pulse = 4'($urandom_range(0, 15));
      default: pulse = 4'b0000;
    endcase
  end

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rst || cnt_clr)           bank[c] <= 16'd0;
      else if (cnt_en && pulse[c])  bank[c] <= bank[c] + 16'd1;
    end
  end

  // Observation log, written only here.
  int          cyc = 0, clr_n = 0, done_n = 0, stab_viol = 0, run_len = 0;
  int          clr_cyc[$], done_cyc[$], en_runs[$];
  logic [63:0] win_exp[$];
  int          got_ch[$], got_cnt[$], got_tr[$];
  int          expp[4] = '{0, 0, 0, 0};
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [1:0]  prev_ch = 2'd0;
  logic [15:0] prev_cnt = 16'd0;
  always @(negedge clk) begin
    cyc++;
    if (cnt_clr) begin
      clr_n++;
      clr_cyc.push_back(cyc);
      for (int c = 0; c < 4; c++) expp[c] = 0;
    end
    if (cnt_en) begin
      run_len++;
      for (int c = 0; c < 4; c++) if (pulse[c]) expp[c]++;
    end else if (run_len > 0) begin
      en_runs.push_back(run_len);
      win_exp.push_back({16'(expp[3]), 16'(expp[2]), 16'(expp[1]), 16'(expp[0])});
      run_len = 0;
    end
    if (done) begin
      done_n++;
      done_cyc.push_back(cyc);
    end
    if (prev_valid && !prev_ready && !rst && (!rd_valid || rd_ch !== prev_ch || rd_cnt !== prev_cnt))
      stab_viol++;
    if (rd_valid && rd_ready) begin
      got_ch.push_back(int'(rd_ch));
      got_cnt.push_back(int'(rd_cnt));
      got_tr.push_back(int'(trunc));
    end
    prev_valid = rd_valid;
    prev_ready = rd_ready;
    prev_ch    = rd_ch;
    prev_cnt   = rd_cnt;
  end

  task automatic add_window(input logic [63:0] s);
    for (int c = 0; c < 4; c++) begin
`ifdef PULSE_CNT_SCHED_SKIP_ZERO_EN
      if (s[c*16 +: 16] == 16'd0) continue;
`endif
      exp_ch.push_back(c);
      exp_cnt.push_back(int'(s[c*16 +: 16]));
    end
  endtask

  task automatic do_start(input int len, input logic c);
    @(posedge clk); #1;
    gate_len = GW'(len);
    cont     = c;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_n < target && n < budget) begin @(negedge clk); n++; end
    while (busy && n < budget) begin @(negedge clk); n++; end
    ok = (done_n >= target) && !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_clr, cnt_en, rd_valid, busy, done, trunc} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {cnt_clr, cnt_en, rd_valid, busy, done, trunc});
    end
    checks++;
    if (rd_ch !== 2'd0 || rd_cnt !== 16'd0 || win_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_data got ch=%0d cnt=%0d win=%0d want 0", rd_ch, rd_cnt, win_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || clr_n !== 0) begin
      errors++; $display("FAIL reset_quiet got busy=%b clr=%0d want 0", busy, clr_n);
    end
  endtask

  task automatic test_single();
    int cb = clr_n, db = done_n, wb = got_ch.size(), rb = en_runs.size();
    bit ok;
    pulse_mode = 1; rd_ready = 1'b1;
    do_start(100, 1'b0);
    wait_done(db + 1, 400, ok);
    exp_ch.delete(); exp_cnt.delete();
    add_window({16'd10, 16'd10, 16'd10, 16'd0});
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got done=%0d want %0d", done_n - db, 1); end
    checks++; if (clr_n - cb != 1) begin errors++; $display("FAIL single_clr got %0d want 1", clr_n - cb); end
    checks++;
    if (en_runs.size() <= rb || en_runs[rb] != 100) begin
      errors++; $display("FAIL single_en_width got %0d want 100", (en_runs.size() > rb) ? en_runs[rb] : -1);
    end
    checks++;
    if (got_ch.size() - wb != exp_ch.size()) begin
      errors++; $display("FAIL single_nwords got %0d want %0d", got_ch.size() - wb, exp_ch.size());
    end
    for (int i = 0; i < exp_ch.size() && wb + i < got_ch.size(); i++) begin
      checks++;
      if (got_ch[wb+i] != exp_ch[i] || got_cnt[wb+i] != exp_cnt[i] || got_tr[wb+i] != 0) begin
        errors++; $display("FAIL single_word%0d got (%0d,%0d,t%0d) want (%0d,%0d,t0)", i,
                           got_ch[wb+i], got_cnt[wb+i], got_tr[wb+i], exp_ch[i], exp_cnt[i]);
      end
    end
    exp_win++;
    checks++; if (done_n - db != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_n - db); end
    checks++; if (win_cnt !== 16'(exp_win)) begin errors++; $display("FAIL single_win got %0d want %0d", win_cnt, exp_win); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    checks++;
    if (done_cyc.size() <= db || done_cyc[db] - clr_cyc[cb] != 1 + 100 + S + 1 + exp_ch.size()) begin
      errors++; $display("FAIL single_budget got %0d want %0d",
                         (done_cyc.size() > db) ? done_cyc[db] - clr_cyc[cb] : -1, 1 + 100 + S + 1 + exp_ch.size());
    end
  endtask

  task automatic test_backpressure();
    int db = done_n, wb = got_ch.size(), xb = win_exp.size(), sb = stab_viol, n = 0;
    pulse_mode = 2;
    do_start(40, 1'b0);
    while ((done_n < db + 1 || busy) && n < 600) begin
      @(posedge clk); #1;
      rd_ready = (n % 3 == 0);
      n++;
    end
    rd_ready = 1'b1;
    exp_ch.delete(); exp_cnt.delete();
    if (win_exp.size() > xb) add_window(win_exp[xb]);
    checks++; if (n >= 600) begin errors++; $display("FAIL bp_timeout got %0d cycles want <600", n); end
    checks++; if (stab_viol != sb) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab_viol - sb); end
    checks++;
    if (got_ch.size() - wb != exp_ch.size()) begin
      errors++; $display("FAIL bp_nwords got %0d want %0d", got_ch.size() - wb, exp_ch.size());
    end
    for (int i = 0; i < exp_ch.size() && wb + i < got_ch.size(); i++) begin
      checks++;
      if (got_ch[wb+i] != exp_ch[i] || got_cnt[wb+i] != exp_cnt[i]) begin
        errors++; $display("FAIL bp_word%0d got (%0d,%0d) want (%0d,%0d)", i, got_ch[wb+i], got_cnt[wb+i], exp_ch[i], exp_cnt[i]);
      end
    end
    exp_win++;
    checks++; if (win_cnt !== 16'(exp_win)) begin errors++; $display("FAIL bp_win got %0d want %0d", win_cnt, exp_win); end
  endtask

  task automatic test_continuous();
    int cb = clr_n, db = done_n, wb = got_ch.size(), xb = win_exp.size(), n = 0;
    bit ok;
    pulse_mode = 2; rd_ready = 1'b1;
    do_start(50, 1'b1);
    while (!(done_n == db + 2 && rd_valid) && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(db + 3, 400, ok);
    repeat (20) @(negedge clk);
    exp_ch.delete(); exp_cnt.delete();
    for (int w = 0; w < 3 && xb + w < win_exp.size(); w++) add_window(win_exp[xb+w]);
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout got done=%0d want 3", done_n - db); end
    checks++; if (done_n - db != 3) begin errors++; $display("FAIL cont_done got %0d want 3", done_n - db); end
    checks++; if (clr_n - cb != 3) begin errors++; $display("FAIL cont_clr got %0d want 3", clr_n - cb); end
    checks++;
    if (got_ch.size() - wb != exp_ch.size()) begin
      errors++; $display("FAIL cont_nwords got %0d want %0d", got_ch.size() - wb, exp_ch.size());
    end
    for (int i = 0; i < exp_ch.size() && wb + i < got_ch.size(); i++) begin
      checks++;
      if (got_ch[wb+i] != exp_ch[i] || got_cnt[wb+i] != exp_cnt[i]) begin
        errors++; $display("FAIL cont_word%0d got (%0d,%0d) want (%0d,%0d)", i, got_ch[wb+i], got_cnt[wb+i], exp_ch[i], exp_cnt[i]);
      end
    end
    for (int w = 0; w < 2 && cb + w + 1 < clr_cyc.size() && db + w < done_cyc.size(); w++) begin
      checks++;
      if (clr_cyc[cb+w+1] != done_cyc[db+w]) begin
        errors++; $display("FAIL cont_gap%0d got clr@%0d want @%0d", w, clr_cyc[cb+w+1], done_cyc[db+w]);
      end
    end
    exp_win += 3;
    checks++; if (win_cnt !== 16'(exp_win)) begin errors++; $display("FAIL cont_win got %0d want %0d", win_cnt, exp_win); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy got %b want 0", busy); end
  endtask

  task automatic test_trunc();
    int cb = clr_n, db = done_n, wb = got_ch.size(), rb = en_runs.size(), xb = win_exp.size(), n = 0, k = 0;
    bit ok;
    pulse_mode = 2; rd_ready = 1'b1;
    do_start(1000, 1'b1);
    while (k < 200 && n < 2000) begin @(negedge clk); n++; if (cnt_en) k++; end
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(db + 1, 200, ok);
    repeat (10) @(negedge clk);
    exp_ch.delete(); exp_cnt.delete();
    if (win_exp.size() > xb) add_window(win_exp[xb]);
    checks++; if (!ok) begin errors++; $display("FAIL trunc_timeout got done=%0d want 1", done_n - db); end
    checks++;
    if (en_runs.size() <= rb || en_runs[rb] != 200) begin
      errors++; $display("FAIL trunc_en_width got %0d want 200", (en_runs.size() > rb) ? en_runs[rb] : -1);
    end
    checks++; if (clr_n - cb != 1) begin errors++; $display("FAIL trunc_clr got %0d want 1", clr_n - cb); end
    checks++;
    if (got_ch.size() - wb != exp_ch.size()) begin
      errors++; $display("FAIL trunc_nwords got %0d want %0d", got_ch.size() - wb, exp_ch.size());
    end
    for (int i = 0; i < exp_ch.size() && wb + i < got_ch.size(); i++) begin
      checks++;
      if (got_ch[wb+i] != exp_ch[i] || got_cnt[wb+i] != exp_cnt[i] || got_tr[wb+i] != 1) begin
        errors++; $display("FAIL trunc_word%0d got (%0d,%0d,t%0d) want (%0d,%0d,t1)", i,
                           got_ch[wb+i], got_cnt[wb+i], got_tr[wb+i], exp_ch[i], exp_cnt[i]);
      end
    end
    exp_win++;
    checks++; if (busy !== 1'b0 || win_cnt !== 16'(exp_win)) begin
      errors++; $display("FAIL trunc_end got busy=%b win=%0d want 0/%0d", busy, win_cnt, exp_win);
    end
  endtask

  task automatic test_zero_counts();
    int cb = clr_n, db = done_n, wb = got_ch.size();
    bit ok;
    pulse_mode = 0; rd_ready = 1'b1;
    do_start(20, 1'b0);
    wait_done(db + 1, 200, ok);
    exp_ch.delete(); exp_cnt.delete();
    add_window(64'd0);
    exp_win++;
    checks++; if (!ok || done_n - db != 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_n - db); end
    checks++;
    if (got_ch.size() - wb != exp_ch.size()) begin
      errors++; $display("FAIL zero_nwords got %0d want %0d", got_ch.size() - wb, exp_ch.size());
    end
    for (int i = 0; i < exp_ch.size() && wb + i < got_ch.size(); i++) begin
      checks++;
      if (got_ch[wb+i] != exp_ch[i] || got_cnt[wb+i] != 0) begin
        errors++; $display("FAIL zero_word%0d got (%0d,%0d) want (%0d,0)", i, got_ch[wb+i], got_cnt[wb+i], exp_ch[i]);
      end
    end
    checks++; if (win_cnt !== 16'(exp_win)) begin errors++; $display("FAIL zero_win got %0d want %0d", win_cnt, exp_win); end
    checks++;
    if (done_cyc.size() <= db || done_cyc[db] - clr_cyc[cb] != 1 + 20 + S + 1 + exp_ch.size()) begin
      errors++; $display("FAIL zero_budget got %0d want %0d",
                         (done_cyc.size() > db) ? done_cyc[db] - clr_cyc[cb] : -1, 1 + 20 + S + 1 + exp_ch.size());
    end
  endtask

  task automatic test_random();
    pulse_mode = 2;
    for (int r = 0; r < 4; r++) begin
      int db = done_n, wb = got_ch.size(), rb = en_runs.size(), xb = win_exp.size(), sb = stab_viol, n = 0;
      int len = $urandom_range(1, 80);
      do_start(len, 1'b0);
      while ((done_n < db + 1 || busy) && n < 800) begin
        @(posedge clk); #1;
        rd_ready = ($urandom_range(0, 9) < 7);
        n++;
      end
      rd_ready = 1'b1;
      exp_ch.delete(); exp_cnt.delete();
      if (win_exp.size() > xb) add_window(win_exp[xb]);
      exp_win++;
      checks++;
      if (n >= 800 || en_runs.size() <= rb || en_runs[rb] != len) begin
        errors++; $display("FAIL rand%0d_en_width got %0d want %0d", r, (en_runs.size() > rb) ? en_runs[rb] : -1, len);
      end
      checks++; if (stab_viol != sb) begin errors++; $display("FAIL rand%0d_stable got %0d want 0", r, stab_viol - sb); end
      checks++;
      if (got_ch.size() - wb != exp_ch.size()) begin
        errors++; $display("FAIL rand%0d_nwords got %0d want %0d", r, got_ch.size() - wb, exp_ch.size());
      end
      for (int i = 0; i < exp_ch.size() && wb + i < got_ch.size(); i++) begin
        checks++;
        if (got_ch[wb+i] != exp_ch[i] || got_cnt[wb+i] != exp_cnt[i]) begin
          errors++; $display("FAIL rand%0d_word%0d got (%0d,%0d) want (%0d,%0d)", r, i,
                             got_ch[wb+i], got_cnt[wb+i], exp_ch[i], exp_cnt[i]);
        end
      end
      checks++; if (win_cnt !== 16'(exp_win)) begin errors++; $display("FAIL rand%0d_win got %0d want %0d", r, win_cnt, exp_win); end
    end
  endtask

  task automatic test_edges();
    int cb, db, rb, n, k;
    bit ok;
    pulse_mode = 0; rd_ready = 1'b1;
    // zero gate length runs as one cycle
    db = done_n; rb = en_runs.size();
    do_start(0, 1'b0);
    wait_done(db + 1, 200, ok);
    exp_win++;
    checks++;
    if (!ok || en_runs.size() <= rb || en_runs[rb] != 1) begin
      errors++; $display("FAIL gate0_width got %0d want 1", (en_runs.size() > rb) ? en_runs[rb] : -1);
    end
    // simultaneous start and stop in IDLE
    cb = clr_n;
    @(posedge clk); #1; gate_len = GW'(10); start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (clr_n != cb || busy !== 1'b0) begin
      errors++; $display("FAIL start_stop got clr=%0d busy=%b want 0/0", clr_n - cb, busy);
    end
    // start while gating is ignored
    cb = clr_n; db = done_n; rb = en_runs.size(); n = 0; k = 0;
    do_start(60, 1'b0);
    while (k < 10 && n < 100) begin @(negedge clk); n++; if (cnt_en) k++; end
    @(posedge clk); #1; gate_len = GW'(5); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(db + 1, 300, ok);
    repeat (5) @(negedge clk);
    exp_win++;
    checks++;
    if (!ok || clr_n - cb != 1 || en_runs.size() <= rb || en_runs[rb] != 60) begin
      errors++; $display("FAIL start_in_gate got clr=%0d width=%0d want 1/60", clr_n - cb, (en_runs.size() > rb) ? en_runs[rb] : -1);
    end
    checks++; if (win_cnt !== 16'(exp_win)) begin errors++; $display("FAIL edges_win got %0d want %0d", win_cnt, exp_win); end
    // asynchronous reset in the middle of the gate
    n = 0; k = 0;
    do_start(100, 1'b0);
    while (k < 30 && n < 200) begin @(negedge clk); n++; if (cnt_en) k++; end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0 || {cnt_clr, rd_valid, busy, done, trunc} !== 5'b0 || win_cnt !== 16'd0 || rd_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_mid_gate got en=%b flags=%b win=%0d want 0", cnt_en, {cnt_clr, rd_valid, busy, done, trunc}, win_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_win = 0;
    cb = clr_n;
    repeat (12) @(negedge clk);
    checks++;
    if (clr_n != cb || busy !== 1'b0 || cnt_en !== 1'b0 || win_cnt !== 16'(exp_win)) begin
      errors++; $display("FAIL rst_quiet got clr=%0d busy=%b en=%b win=%0d want 0", clr_n - cb, busy, cnt_en, win_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_continuous();
    test_trunc();
    test_zero_counts();
    test_random();
    test_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_cnt_sched.md
Name: pulse_cnt_sched

Overview:
Measurement-window scheduler for the 4-channel 16-bit pulse counter bank. Sequences each window as clear, then gate (enable) for a programmed cycle count, then settle, then snapshot. Streams the four captured counts out over a valid/ready interface. Supports single-shot and continuous back-to-back windows.

Parameters:
SETTLE_CYCLES, 4, cycles counter enable stays low after gate before capture (covers counter sync/edge pipeline); legal range 1-15
GATE_W, 24, width of the gate-length input

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start request; accepted only in IDLE
i_stop  in  1  stop request; truncates the gate and ends continuous mode
i_cont  in  1  continuous mode; sampled with i_start
i_gate_len  in  GATE_W  gate length in cycles; sampled with i_start; 0 is treated as 1
i_cnt0..i_cnt3  in  16 each  counts from the counter bank
o_cnt_clr  out  1  counter clear strobe
o_cnt_en  out  1  counter enable (gate)
o_rd_valid  out  1  result word valid
o_rd_ch  out  2  channel index of the result word
o_rd_cnt  out  16  captured count
i_rd_ready  in  1  consumer ready
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when a window's readout completes
o_trunc  out  1  high while presenting words of a window whose gate was cut short by i_stop
o_win_cnt  out  16  number of completed windows; wraps at 0xFFFF->0

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs 0: o_cnt_clr, o_cnt_en, o_rd_valid, o_rd_ch, o_rd_cnt, o_busy, o_done, o_trunc, o_win_cnt. Internal latches are cleared.
- Reset mid-window drops o_cnt_en and o_rd_valid immediately. After reset release, nothing happens until a new i_start.
- States: IDLE, CLEAR, GATE, SETTLE, CAPTURE, OUT. All outputs are registered.
- IDLE: on i_start=1 with i_stop=0, latch gate_len (0 becomes 1) and cont, then go to CLEAR. If i_start and i_stop are high together, the stop wins and the FSM stays in IDLE.
- CLEAR: o_cnt_clr=1 for exactly 1 cycle, then GATE.
- GATE: o_cnt_en=1 for exactly gate_len cycles, then SETTLE.
  - i_stop in GATE: o_cnt_en drops the next cycle, the window is marked truncated, and the FSM goes to SETTLE.
- SETTLE: o_cnt_en=0 for SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE: register i_cnt0..3 in 1 cycle, then OUT with ch=0.
- OUT: o_rd_valid=1 with o_rd_ch=ch and o_rd_cnt=snapshot[ch].
  - Valid and data stay stable until i_rd_ready=1. Each transfer happens on the cycle where valid and ready are both 1.
  - After the ch=3 transfer: o_done=1 for 1 cycle, o_win_cnt increments, o_rd_valid drops.
  - Next state is CLEAR if cont is latched and no stop is pending; otherwise IDLE.
  - Total latency from ch3 transfer to next o_cnt_clr in continuous mode: 1 cycle.
- i_stop in CLEAR, SETTLE, CAPTURE or OUT sets stop_pending. The current window completes, and the FSM then returns to IDLE. stop_pending clears on entering IDLE.
- i_start while busy is ignored. i_stop in IDLE is ignored.
- i_rd_ready may be held high permanently; the four words then go out on 4 consecutive cycles.
- Snapshots are not saturated or modified; counter wrap is the counter's responsibility.
- Window cycle budget, no backpressure and ready always high: 1 (CLEAR) + gate_len + SETTLE_CYCLES + 1 (CAPTURE) + 4 (OUT).

Optional Feature:
PULSE_CNT_SCHED_SKIP_ZERO_EN
- Defined: during OUT, channels whose snapshot is 0 are skipped and never presented.
  - If all four are 0, no word is presented; o_done still pulses 1 cycle after CAPTURE and o_win_cnt still increments.
  - o_rd_ch still carries the true channel index.
- Undefined: all four channels are always presented in order 0,1,2,3.

Test Plan:
- Single shot, i_gate_len=100, i_cont=0, counter model fed 10 pulses on ch1-3 in window -> exactly one o_cnt_clr; o_cnt_en high 100 cycles; words (0,0),(1,10),(2,10),(3,10); o_done once; o_win_cnt=1; back in IDLE, o_busy=0.
- Backpressure: i_rd_ready toggles 1 of every 3 cycles -> o_rd_ch/o_rd_cnt stable while valid and not ready; exactly 4 transfers, in order.
- Continuous, i_gate_len=50, 3 windows then i_stop asserted during OUT of window 3 -> 3 o_done pulses; o_win_cnt=3; no 4th o_cnt_clr; IDLE.
- Truncation: i_gate_len=1000, i_stop at gate cycle 200 -> o_cnt_en width 200 (+1 stop latency); o_trunc=1 on all 4 words; then IDLE.
- Edges: i_gate_len=0 gives o_cnt_en for 1 cycle. i_start+i_stop in same IDLE cycle gives no start. i_start during GATE is ignored. i_rst at GATE cycle 30 gives o_cnt_en=0 immediately and all outputs 0.
- With PULSE_CNT_SCHED_SKIP_ZERO_EN, counts {0,5,0,7} -> only (1,5),(3,7) presented. Counts all 0 -> no valid, o_done pulses, o_win_cnt increments.
